boot_mem_loader: RTL and testbench
==================================

BOOT_MEM_LOADER -- requirements
Module: boot_mem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: width of mem_addr, load_len and the byte counter.
REQ-002 Parameter DEPTH, default 256: number of 8-bit storage words, equal to 2**ADDR_WIDTH.
REQ-003 Parameter RELEASE_CYCLES, default 2: cycles the core reset stays low after the last byte is written.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 arst_n  input  1  asynchronous, active-low reset.
REQ-006 load_start  input  1  one-cycle pulse requesting a program download.
REQ-007 load_len  input  ADDR_WIDTH  byte count, sampled with load_start; 0 means DEPTH bytes.
REQ-008 load_valid  input  1  load_data holds a valid byte.
REQ-009 load_data  input  8  program byte.
REQ-010 load_ready  output  1  high only in LOAD; a byte is accepted when load_valid and load_ready are both high on a rising edge.
REQ-011 mem_addr  input  ADDR_WIDTH  processor fetch or store address.
REQ-012 mem_write_en  input  1  processor store strobe.
REQ-013 mem_data  inout  8  bidirectional bus shared with the processor.
REQ-014 core_arst_n  output  1  registered active-low reset driving the processor's arst_n.
REQ-015 load_done  output  1  one-cycle pulse on entry to RUN.

Function
REQ-016 FSM states: IDLE, LOAD, RELEASE, RUN.
REQ-017 IDLE: core_arst_n=0, load_ready=0, mem_data=Z; load_start -> LOAD.
REQ-018 On entry to LOAD: byte counter=0; remaining count is loaded from load_len, with 0 mapped to DEPTH.
REQ-019 LOAD, per accepted byte: mem[counter] is written with load_data, and counter increments by 1.
REQ-020 LOAD ends when the accepted byte is the final one; in that same cycle the next state is RELEASE.
REQ-021 load_len=0 writes all DEPTH words; the counter wraps to 0 without being used again.
REQ-022 LOAD: load_valid=0 stalls the counter with no timeout; load_start is ignored.
REQ-023 LOAD: core_arst_n=0 and mem_data=Z.
REQ-024 RELEASE: core_arst_n stays 0 for RELEASE_CYCLES cycles, counted by a release counter, then -> RUN.
REQ-025 RUN: core_arst_n=1; load_done=1 on the first RUN cycle only.
REQ-026 RUN, read: with mem_write_en=0, mem_data = mem[mem_addr] combinationally, so a fetch completes in the same cycle.
REQ-027 RUN, write: with mem_write_en=1, mem_data is released (Z) and mem[mem_addr] is written with mem_data on the rising edge.
REQ-028 RUN: load_start -> LOAD on the next edge and reasserts core_arst_n=0 (re-download).
REQ-029 load_start with load_valid in IDLE or RUN: that byte is not accepted because load_ready=0.
REQ-030 The block never drives mem_data in a cycle where mem_write_en=1, in any state.

Reset
REQ-031 arst_n low, asynchronously: state=IDLE, counters=0, core_arst_n=0, load_ready=0, load_done=0, mem_data=Z.
REQ-032 Storage contents are not reset; arst_n during LOAD aborts the download, and bytes already written are kept.
REQ-033 After reset is released the block waits in IDLE for load_start; the core is never released without a completed download.

Structure
REQ-034 A shared package holds the FSM state encoding (2-bit typedef) and the ADDR_WIDTH/DEPTH defaults used by the processor top.
REQ-035 Sub-module sp_ram_async_rd: DEPTH x 8 storage with one synchronous write port and an asynchronous read.
REQ-036 Its write port is muxed: loader in LOAD, processor in RUN.

Verification
REQ-037 Reset, then load_start with load_len=4 and bytes A0,A1,A2,A3 with valid held high -> mem[0..3]=A0..A3; 2 RELEASE cycles; core_arst_n rises; load_done pulses once.
REQ-038 Same load with load_valid toggled 1,0,1,0 -> counter stalls on the gaps; final contents and ordering unchanged.
REQ-039 load_len=0 with 256 bytes equal to their index -> mem[255]=FF and mem[0]=00 after wrap; RUN entered.
REQ-040 RUN, mem_addr=02, mem_write_en=0 -> mem_data=A2 in the same cycle; mem_write_en=1 with bus=5C at addr 10 -> mem[10]=5C, block drives Z.
REQ-041 arst_n pulsed low after 2 of 4 bytes -> IDLE, core_arst_n=0, mem[0..1] kept; a fresh load completes normally.
REQ-042 load_start in RUN -> core_arst_n=0 on the next edge, LOAD entered; load_start pulsed again during LOAD is ignored.

Source files
------------

// File: rtl/boot_mem_loader_pkg.sv
// Shared definitions for the boot memory loader: FSM state encoding and the
// default geometry used by the processor top.
package boot_mem_loader_pkg;

  localparam int DEFAULT_ADDR_WIDTH     = 8;
  localparam int DEFAULT_DEPTH          = 1 << DEFAULT_ADDR_WIDTH;
  localparam int DEFAULT_RELEASE_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } loader_state_e;

endpackage

// File: rtl/boot_mem_loader_if.sv
// Download stream, processor address/strobe and core-reset signals of the
// boot memory loader; the bidirectional data bus stays a plain inout port.
interface boot_mem_loader_if
  import boot_mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

  logic                  load_start;
  logic [ADDR_WIDTH-1:0] load_len;
  logic                  load_valid;
  logic [7:0]            load_data;
  logic                  load_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_write_en;
  logic                  core_arst_n;
  logic                  load_done;

  modport master (
    output load_start, load_len, load_valid, load_data, mem_addr, mem_write_en,
    input  load_ready, core_arst_n, load_done
  );

  modport slave (
    input  load_start, load_len, load_valid, load_data, mem_addr, mem_write_en,
    output load_ready, core_arst_n, load_done
  );

endinterface

// File: rtl/boot_mem_loader_sp_ram_async_rd.sv
// DEPTH x 8 storage with one synchronous write port and an asynchronous read
// port; contents are deliberately never reset.
module sp_ram_async_rd #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [7:0]            i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [7:0]            o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/boot_mem_loader.sv
// Boot loader: holds the processor in reset while a program is streamed into
// local RAM, then releases it and serves fetches/stores over a shared bus.
module boot_mem_loader
  import boot_mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH          = DEFAULT_DEPTH,
  parameter int RELEASE_CYCLES = DEFAULT_RELEASE_CYCLES
) (
  input  logic              clk,
  input  logic              arst_n,
  boot_mem_loader_if.slave  bus,
  inout  wire  [7:0]        mem_data
);

  localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [REL_W-1:0]    REL_LAST   = REL_W'(RELEASE_CYCLES - 1);

  loader_state_e         r_state;
  logic [ADDR_WIDTH-1:0] r_byteCount;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [REL_W-1:0]      r_releaseCount;
  logic                  r_coreArstN;
  logic                  r_loadReady;
  logic                  r_loadDone;

  logic                  w_accept;
  logic                  w_lastByte;
  logic                  w_ramWe;
  logic [ADDR_WIDTH-1:0] w_ramWaddr;
  logic [7:0]            w_ramWdata;
  logic [7:0]            w_ramRdata;
  logic                  w_driveEn;
  logic [ADDR_WIDTH:0]   w_startCount;

  assign w_accept     = r_loadReady && bus.load_valid;
  assign w_lastByte   = w_accept && (r_remaining == (ADDR_WIDTH + 1)'(1));
  assign w_startCount = (bus.load_len == '0) ? FULL_COUNT : {1'b0, bus.load_len};

  // Write port belongs to the loader during LOAD and to the processor in RUN.
  always_comb begin
    w_ramWe    = 1'b0;
    w_ramWaddr = r_byteCount;
    w_ramWdata = bus.load_data;
    case (r_state)
      ST_LOAD: w_ramWe = w_accept;
      ST_RUN: begin
        w_ramWe    = bus.mem_write_en;
        w_ramWaddr = bus.mem_addr;
        w_ramWdata = mem_data;
      end
      default: w_ramWe = 1'b0;
    endcase
  end

  assign w_driveEn = (r_state == ST_RUN) && !bus.mem_write_en;
  assign mem_data  = w_driveEn ? w_ramRdata : 8'bz;

  sp_ram_async_rd #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ramWe),
    .i_waddr (w_ramWaddr),
    .i_wdata (w_ramWdata),
    .i_raddr (bus.mem_addr),
    .o_rdata (w_ramRdata)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state        <= ST_IDLE;
      r_byteCount    <= '0;
      r_remaining    <= '0;
      r_releaseCount <= '0;
      r_coreArstN    <= 1'b0;
      r_loadReady    <= 1'b0;
      r_loadDone     <= 1'b0;
    end else begin
      r_loadDone <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.load_start) begin
            r_state     <= ST_LOAD;
            r_byteCount <= '0;
            r_remaining <= w_startCount;
            r_loadReady <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_byteCount <= r_byteCount + 1'b1;
            r_remaining <= r_remaining - 1'b1;
          end
          if (w_lastByte) begin
            r_state        <= ST_RELEASE;
            r_loadReady    <= 1'b0;
            r_releaseCount <= '0;
          end
        end
        ST_RELEASE: begin
          if (r_releaseCount == REL_LAST) begin
            r_state     <= ST_RUN;
            r_coreArstN <= 1'b1;
            r_loadDone  <= 1'b1;
          end else begin
            r_releaseCount <= r_releaseCount + 1'b1;
          end
        end
        ST_RUN: begin
          // A new download puts the core straight back into reset.
          if (bus.load_start) begin
            r_state     <= ST_LOAD;
            r_byteCount <= '0;
            r_remaining <= w_startCount;
            r_loadReady <= 1'b1;
            r_coreArstN <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.load_ready  = r_loadReady;
  assign bus.core_arst_n = r_coreArstN;
  assign bus.load_done   = r_loadDone;

endmodule

// File: tb/tb_boot_mem_loader.sv
// Directed self-checking bench for boot_mem_loader: download, stalls, full
// wrap, processor read/write, abort by reset and re-download from RUN.
module tb_boot_mem_loader;
  import boot_mem_loader_pkg::*;

  logic       clk;
  logic       arst_n;
  logic [7:0] tbDrive;
  logic       tbDriveEn;
  wire  [7:0] mem_data;
  int         compared;
  int         mismatched;

  boot_mem_loader_if #(.ADDR_WIDTH(8)) bus ();

  boot_mem_loader #(
    .ADDR_WIDTH     (8),
    .DEPTH          (256),
    .RELEASE_CYCLES (2)
  ) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .bus      (bus.slave),
    .mem_data (mem_data)
  );

  assign mem_data = tbDriveEn ? tbDrive : 8'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startLoad(input logic [7:0] len);
    bus.load_start = 1'b1;
    bus.load_len   = len;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] d);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic readMem(input logic [7:0] addr, output logic [7:0] d);
    bus.mem_write_en = 1'b0;
    bus.mem_addr     = addr;
    #1;
    d = mem_data;
  endtask

  // Counts cycles until core reset is released; -1 when the budget runs out.
  task automatic waitRun(output int cycles);
    cycles = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.core_arst_n === 1'b1) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    bus.load_start = 1'b0; bus.load_len = '0; bus.load_valid = 1'b0;
    bus.load_data = '0; bus.mem_addr = '0; bus.mem_write_en = 1'b0;
    tbDrive = '0; tbDriveEn = 1'b0;
    #23;
    compared++;
    if (dut.r_state !== ST_IDLE || bus.core_arst_n !== 1'b0 || bus.load_ready !== 1'b0
        || bus.load_done !== 1'b0 || dut.w_driveEn !== 1'b0 || dut.r_byteCount !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL reset: state=%0d core=%b ready=%b done=%b drive=%b cnt=%0d, need IDLE/0/0/0/0/0",
               dut.r_state, bus.core_arst_n, bus.load_ready, bus.load_done, dut.w_driveEn, dut.r_byteCount);
    end
    tick();
    arst_n = 1'b1;
    tick();
    tick();
    compared++;
    if (dut.r_state !== ST_IDLE || bus.core_arst_n !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL idle_wait: state=%0d core=%b, need IDLE/0", dut.r_state, bus.core_arst_n);
    end
  endtask

  task automatic test_basic_load();
    logic [7:0] d;
    int cyc;
    int pulses;
    startLoad(8'd4);
    compared++;
    if (dut.r_state !== ST_LOAD || bus.load_ready !== 1'b1 || bus.core_arst_n !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL load_entry: state=%0d ready=%b core=%b, need LOAD/1/0",
               dut.r_state, bus.load_ready, bus.core_arst_n);
    end
    for (int i = 0; i < 4; i++) sendByte(8'hA0 + 8'(i));
    compared++;
    if (dut.r_state !== ST_RELEASE || bus.load_ready !== 1'b0 || bus.core_arst_n !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL release_entry: state=%0d ready=%b core=%b, need RELEASE/0/0",
               dut.r_state, bus.load_ready, bus.core_arst_n);
    end
    waitRun(cyc);
    compared++;
    if (cyc != 2) begin
      mismatched++;
      $display("[TB] FAIL release_cycles: got %0d, need 2", cyc);
    end
    pulses = (bus.load_done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.load_done === 1'b1) pulses++;
    end
    compared++;
    if (pulses != 1 || dut.r_state !== ST_RUN) begin
      mismatched++;
      $display("[TB] FAIL load_done_pulse: pulses=%0d state=%0d, need 1/RUN", pulses, dut.r_state);
    end
    for (int i = 0; i < 4; i++) begin
      readMem(8'(i), d);
      compared++;
      if (d !== 8'hA0 + 8'(i)) begin
        mismatched++;
        $display("[TB] FAIL basic_mem[%0d]: got %h, need %h", i, d, 8'hA0 + 8'(i));
      end
    end
  endtask

  task automatic test_run_rw();
    logic [7:0] d;
    readMem(8'h02, d);
    compared++;
    if (d !== 8'hA2 || dut.w_driveEn !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL run_read: data=%h drive=%b, need A2/1", d, dut.w_driveEn);
    end
    bus.mem_addr = 8'h10; bus.mem_write_en = 1'b1;
    tbDrive = 8'h5C; tbDriveEn = 1'b1;
    #1;
    compared++;
    if (dut.w_driveEn !== 1'b0 || mem_data !== 8'h5C) begin
      mismatched++;
      $display("[TB] FAIL run_write_bus: drive=%b bus=%h, need 0/5C", dut.w_driveEn, mem_data);
    end
    tick();
    tbDriveEn = 1'b0;
    readMem(8'h10, d);
    compared++;
    if (d !== 8'h5C) begin
      mismatched++;
      $display("[TB] FAIL run_write_mem: got %h, need 5C", d);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    int cyc;
    startLoad(8'd0);
    for (int i = 0; i < 256; i++) sendByte(8'(i));
    compared++;
    if (dut.r_state !== ST_RELEASE || dut.r_byteCount !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL wrap_end: state=%0d cnt=%0d, need RELEASE/0", dut.r_state, dut.r_byteCount);
    end
    waitRun(cyc);
    compared++;
    if (cyc != 2 || dut.r_state !== ST_RUN) begin
      mismatched++;
      $display("[TB] FAIL wrap_run: cycles=%0d state=%0d, need 2/RUN", cyc, dut.r_state);
    end
    readMem(8'hFF, d);
    compared++;
    if (d !== 8'hFF) begin
      mismatched++;
      $display("[TB] FAIL wrap_mem[255]: got %h, need FF", d);
    end
    readMem(8'h00, d);
    compared++;
    if (d !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL wrap_mem[0]: got %h, need 00", d);
    end
    readMem(8'h80, d);
    compared++;
    if (d !== 8'h80) begin
      mismatched++;
      $display("[TB] FAIL wrap_mem[128]: got %h, need 80", d);
    end
  endtask

  task automatic test_stall();
    logic [7:0] d;
    int cyc;
    startLoad(8'd4);
    for (int i = 0; i < 7; i++) begin
      bus.load_valid = (i % 2 == 0);
      bus.load_data  = (i % 2 == 0) ? 8'hA0 + 8'(i / 2) : 8'hEE;
      tick();
      if (i % 2 == 1) begin
        compared++;
        if (dut.r_byteCount !== 8'(i / 2 + 1)) begin
          mismatched++;
          $display("[TB] FAIL stall_cnt[%0d]: got %0d, need %0d", i, dut.r_byteCount, i / 2 + 1);
        end
      end
    end
    bus.load_valid = 1'b0;
    waitRun(cyc);
    compared++;
    if (cyc != 2) begin
      mismatched++;
      $display("[TB] FAIL stall_release: got %0d, need 2", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      readMem(8'(i), d);
      compared++;
      if (d !== 8'hA0 + 8'(i)) begin
        mismatched++;
        $display("[TB] FAIL stall_mem[%0d]: got %h, need %h", i, d, 8'hA0 + 8'(i));
      end
    end
  endtask

  task automatic test_reload_from_run();
    logic [7:0] d;
    int cyc;
    bus.load_start = 1'b1; bus.load_len = 8'd2;
    bus.load_valid = 1'b1; bus.load_data = 8'hFF;
    tick();
    bus.load_start = 1'b0; bus.load_valid = 1'b0;
    compared++;
    if (bus.core_arst_n !== 1'b0 || dut.r_state !== ST_LOAD || dut.r_byteCount !== 8'd0
        || dut.u_ram.r_mem[0] !== 8'hA0) begin
      mismatched++;
      $display("[TB] FAIL reload_entry: core=%b state=%0d cnt=%0d mem0=%h, need 0/LOAD/0/A0",
               bus.core_arst_n, dut.r_state, dut.r_byteCount, dut.u_ram.r_mem[0]);
    end
    sendByte(8'hC0);
    bus.load_start = 1'b1; bus.load_len = 8'd4;
    tick();
    bus.load_start = 1'b0;
    compared++;
    if (dut.r_state !== ST_LOAD || dut.r_byteCount !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL start_ignored: state=%0d cnt=%0d, need LOAD/1", dut.r_state, dut.r_byteCount);
    end
    sendByte(8'hC1);
    compared++;
    if (dut.r_state !== ST_RELEASE) begin
      mismatched++;
      $display("[TB] FAIL reload_len: state=%0d, need RELEASE", dut.r_state);
    end
    waitRun(cyc);
    readMem(8'h00, d);
    compared++;
    if (cyc != 2 || d !== 8'hC0) begin
      mismatched++;
      $display("[TB] FAIL reload_mem0: cycles=%0d data=%h, need 2/C0", cyc, d);
    end
    readMem(8'h01, d);
    compared++;
    if (d !== 8'hC1) begin
      mismatched++;
      $display("[TB] FAIL reload_mem1: got %h, need C1", d);
    end
    readMem(8'h02, d);
    compared++;
    if (d !== 8'hA2) begin
      mismatched++;
      $display("[TB] FAIL reload_mem2: got %h, need A2", d);
    end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    int cyc;
    startLoad(8'd4);
    sendByte(8'hD0);
    sendByte(8'hD1);
    #2;
    arst_n = 1'b0;
    #1;
    compared++;
    if (dut.r_state !== ST_IDLE || bus.core_arst_n !== 1'b0 || bus.load_ready !== 1'b0
        || dut.r_byteCount !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL abort_state: state=%0d core=%b ready=%b cnt=%0d, need IDLE/0/0/0",
               dut.r_state, bus.core_arst_n, bus.load_ready, dut.r_byteCount);
    end
    compared++;
    if (dut.u_ram.r_mem[0] !== 8'hD0 || dut.u_ram.r_mem[1] !== 8'hD1 || dut.u_ram.r_mem[2] !== 8'hA2) begin
      mismatched++;
      $display("[TB] FAIL abort_kept: mem0=%h mem1=%h mem2=%h, need D0/D1/A2",
               dut.u_ram.r_mem[0], dut.u_ram.r_mem[1], dut.u_ram.r_mem[2]);
    end
    tick();
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    compared++;
    if (dut.r_state !== ST_IDLE || bus.core_arst_n !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL abort_idle: state=%0d core=%b, need IDLE/0", dut.r_state, bus.core_arst_n);
    end
    startLoad(8'd4);
    for (int i = 0; i < 4; i++) sendByte(8'hE0 + 8'(i));
    waitRun(cyc);
    compared++;
    if (cyc != 2) begin
      mismatched++;
      $display("[TB] FAIL fresh_release: got %0d, need 2", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      readMem(8'(i), d);
      compared++;
      if (d !== 8'hE0 + 8'(i)) begin
        mismatched++;
        $display("[TB] FAIL fresh_mem[%0d]: got %h, need %h", i, d, 8'hE0 + 8'(i));
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_basic_load();
    test_run_rw();
    test_wrap();
    test_stall();
    test_reload_from_run();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
